// File: rtl/dfr_axi_pkg.sv
// Shared types for the DFR AXI4-Lite command master.
// State encoding, AXI response codes and command/response bundles.
package dfr_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_RSP,
      ST_ERR
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

   typedef struct packed {
      logic                  write;
      logic [AXI_DATA_W-1:0] wdata;
      logic [AXI_STRB_W-1:0] wstrb;
   } cmd_t;

   typedef struct packed {
      logic [AXI_DATA_W-1:0] rdata;
      logic [1:0]            resp;
      logic                  write;
   } rsp_t;

endpackage

// File: rtl/dfr_axi_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: command stream in, response out.
// A per-phase watchdog parks the block in ERR if the slave hangs.
module dfr_axi_cmd_master
   import dfr_axi_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 16,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_write,
   output logic                              error,
   output logic                              busy,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   cmd_t                            cmd_q, cmd_d;
   rsp_t                            rsp_q, rsp_d;
   logic                            awvalid_q, awvalid_d;
   logic                            wvalid_q, wvalid_d;
   logic                            bready_q, bready_d;
   logic                            arvalid_q, arvalid_d;
   logic                            rready_q, rready_d;
   logic                            error_q, error_d;

   logic                            watched;
   logic                            timeout;
   logic [CNT_W-1:0]                cnt_inc;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      rsp_d     = rsp_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      error_d   = error_q;
      watched   = 1'b0;
      timeout   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d      = cmd_addr;
               cmd_d.write = cmd_write;
               cmd_d.wdata = cmd_wdata;
               cmd_d.wstrb = cmd_wstrb;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR_REQ;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: begin
            watched = 1'b1;
            // AW and W retire independently; B opens once both are gone
            if (M_AXI_AWREADY) awvalid_d = 1'b0;
            if (M_AXI_WREADY)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            watched = 1'b1;
            if (M_AXI_BVALID) begin
               rsp_d.rdata = '0;
               rsp_d.resp  = M_AXI_BRESP;
               rsp_d.write = 1'b1;
               bready_d    = 1'b0;
               state_d     = ST_RSP;
            end
         end
         ST_RD_REQ: begin
            watched = 1'b1;
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            watched = 1'b1;
            if (M_AXI_RVALID) begin
               rsp_d.rdata = M_AXI_RDATA;
               rsp_d.resp  = M_AXI_RRESP;
               rsp_d.write = 1'b0;
               rready_d    = 1'b0;
               state_d     = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Progress in the same cycle wins over the watchdog
      timeout = (TIMEOUT_CYCLES > 0) && watched &&
                (state_d == state_q) &&
                (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

      if (timeout) begin
         state_d   = ST_ERR;
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
         error_d   = 1'b1;
      end

      if (state_d != state_q) cnt_d = '0;
      else if (watched)       cnt_d = cnt_inc;
      else                    cnt_d = '0;
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         cmd_q     <= '0;
         rsp_q     <= '{rdata: '0, resp: RESP_OKAY, write: 1'b0};
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         cmd_q     <= cmd_d;
         rsp_q     <= rsp_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         error_q   <= error_d;
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign rsp_valid     = (state_q == ST_RSP);
   assign rsp_rdata     = rsp_q.rdata;
   assign rsp_resp      = rsp_q.resp;
   assign rsp_write     = rsp_q.write;
   assign error         = error_q;

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = cmd_q.wdata;
   assign M_AXI_WSTRB   = cmd_q.wstrb;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_dfr_axi_cmd_master.sv
// Bench for dfr_axi_cmd_master: configurable-latency AXI-Lite memory
// slave plus a word-level memory model predicting every response.
module tb_dfr_axi_cmd_master;
   import dfr_axi_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 16;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          rsp_write, error, busy;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready;
   logic          bvalid, bready, arvalid, arready;
   logic          rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   int total = 0;
   int bad   = 0;

   dfr_axi_cmd_master #(
      .C_M_AXI_ADDR_WIDTH(AW),
      .C_M_AXI_DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .M_AXI_ACLK(clk),       .M_AXI_ARESETN(rstn),
      .cmd_valid(cmd_valid),  .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),  .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata),  .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid),  .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),  .rsp_resp(rsp_resp),
      .rsp_write(rsp_write),  .error(error), .busy(busy),
      .M_AXI_AWADDR(awaddr),  .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata),    .M_AXI_WSTRB(wstrb),
      .M_AXI_WVALID(wvalid),  .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp),    .M_AXI_BVALID(bvalid),
      .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr),  .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata),    .M_AXI_RRESP(rresp),
      .M_AXI_RVALID(rvalid),  .M_AXI_RREADY(rready)
   );

   function automatic logic [31:0] merge(input logic [31:0] o,
                                         input logic [31:0] d,
                                         input logic [3:0]  s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++)
         if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // ---------------- slave ----------------
   int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   bit ar_never = 0;
   logic [1:0] s_bresp = RESP_OKAY;
   logic [1:0] s_rresp = RESP_OKAY;
   int aw_age = 0, w_age = 0, ar_age = 0, b_cnt = 0, r_cnt = 0;
   bit b_pend = 0, r_pend = 0, aw_got = 0, w_got = 0;
   int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
   logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
   logic [DW-1:0] s_wdata = '0, r_q = '0;
   logic [3:0]    s_wstrb = '0;
   logic [1:0]    b_q = '0, rr_q = '0;
   logic [31:0]   smem [16] = '{1: 32'h12345678, default: 32'h0};
   logic [31:0]   mmem [16] = '{1: 32'h12345678, default: 32'h0};

   logic aw_hs, w_hs, ar_hs, aw_now, w_now;
   logic [3:0]  wr_idx;
   logic [31:0] wr_d;
   logic [3:0]  wr_s;

   assign awready = awvalid && (aw_age >= aw_wait);
   assign wready  = wvalid && (w_age >= w_wait);
   assign arready = arvalid && !ar_never && (ar_age >= ar_wait);
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign ar_hs   = arvalid && arready;
   assign aw_now  = aw_got || aw_hs;
   assign w_now   = w_got || w_hs;
   assign wr_idx  = aw_hs ? awaddr[5:2] : s_awaddr[5:2];
   assign wr_d    = w_hs ? wdata : s_wdata;
   assign wr_s    = w_hs ? wstrb : s_wstrb;
   assign bvalid  = b_pend && (b_cnt == 0);
   assign bresp   = b_q;
   assign rvalid  = r_pend && (r_cnt == 0);
   assign rdata   = r_q;
   assign rresp   = rr_q;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_age <= 0; w_age <= 0; ar_age <= 0;
         b_pend <= 0; r_pend <= 0; b_cnt <= 0; r_cnt <= 0;
         aw_got <= 0; w_got <= 0;
      end else begin
         aw_age <= (awvalid && !awready) ? aw_age + 1 : 0;
         w_age  <= (wvalid && !wready) ? w_age + 1 : 0;
         ar_age <= (arvalid && !arready) ? ar_age + 1 : 0;
         if (aw_hs) begin
            s_awaddr <= awaddr;
            aw_hs_n  <= aw_hs_n + 1;
         end
         if (w_hs) begin
            s_wdata <= wdata;
            s_wstrb <= wstrb;
            w_hs_n  <= w_hs_n + 1;
         end
         if (aw_now && w_now && !b_pend) begin
            b_pend <= 1; b_cnt <= b_wait; b_q <= s_bresp;
            aw_got <= 0; w_got <= 0;
            smem[wr_idx] <= merge(smem[wr_idx], wr_d, wr_s);
         end else begin
            if (aw_hs) aw_got <= 1;
            if (w_hs)  w_got  <= 1;
         end
         if (b_pend) begin
            if (bvalid && bready) b_pend <= 0;
            else if (b_cnt > 0)   b_cnt  <= b_cnt - 1;
         end
         if (ar_hs && !r_pend) begin
            r_pend   <= 1; r_cnt <= r_wait;
            r_q      <= smem[araddr[5:2]];
            rr_q     <= s_rresp;
            s_araddr <= araddr;
            ar_hs_n  <= ar_hs_n + 1;
         end else if (r_pend) begin
            if (rvalid && rready) r_pend <= 0;
            else if (r_cnt > 0)   r_cnt  <= r_cnt - 1;
         end
      end
   end

   // ---------------- protocol monitor ----------------
   int viol = 0, rb_viol = 0;
   logic p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0;
   logic [AW-1:0] p_awa = '0, p_ara = '0;
   logic [DW-1:0] p_wd = '0;
   logic [3:0]    p_ws = '0;

   always @(negedge clk) begin
      if (rstn && (cmd_ready === busy)) rb_viol <= rb_viol + 1;
      if (!rstn || error) begin
         p_aw <= 0; p_w <= 0; p_ar <= 0;
      end else begin
         if ((p_aw && !p_awr && (!awvalid || awaddr !== p_awa)) ||
             (p_w && !p_wr && (!wvalid || wdata !== p_wd ||
                               wstrb !== p_ws)) ||
             (p_ar && !p_arr && (!arvalid || araddr !== p_ara)))
            viol <= viol + 1;
         p_aw <= awvalid; p_awr <= awready; p_awa <= awaddr;
         p_w  <= wvalid;  p_wr  <= wready;  p_wd  <= wdata;
         p_ws <= wstrb;
         p_ar <= arvalid; p_arr <= arready; p_ara <= araddr;
      end
   end

   // ---------------- model and driver ----------------
   task automatic model_apply(input bit w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d,
                              input logic [3:0] s,
                              output logic [DW-1:0] erd,
                              output logic [1:0] err);
      if (w) begin
         mmem[a[5:2]] = merge(mmem[a[5:2]], d, s);
         erd = '0;
         err = s_bresp;
      end else begin
         erd = mmem[a[5:2]];
         err = s_rresp;
      end
   endtask

   // Call just after a negedge; returns after rsp handshake if rsp_ready
   task automatic do_cmd(input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] s,
                         output logic [DW-1:0] rd, output logic [1:0] rr,
                         output logic rw, output int lat, output bit tmo);
      int n;
      n = 0; tmo = 0; lat = 0; rd = '0; rr = '0; rw = 0;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      cmd_valid = 1;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         cmd_valid = 0; tmo = 1;
         return;
      end
      @(posedge clk);
      #1 cmd_valid = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 100);
      if (!rsp_valid) begin
         tmo = 1;
         return;
      end
      rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
      if (rsp_ready) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 0;
      repeat (3) @(negedge clk);
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
         bad++;
         $display("FAIL reset_valids got=%b exp=00000",
                  {awvalid, wvalid, bready, arvalid, rready});
      end
      total++;
      if ({rsp_valid, rsp_rdata, rsp_resp, rsp_write} !== '0) begin
         bad++;
         $display("FAIL reset_rsp got v=%b d=%h r=%b w=%b exp 0",
                  rsp_valid, rsp_rdata, rsp_resp, rsp_write);
      end
      total++;
      if ({error, busy, cmd_ready} !== 3'b001) begin
         bad++;
         $display("FAIL reset_status got=%b exp=001",
                  {error, busy, cmd_ready});
      end
      total++;
      if ({awaddr, araddr, wdata, wstrb} !== '0) begin
         bad++;
         $display("FAIL reset_payload got aw=%h ar=%h wd=%h ws=%h exp 0",
                  awaddr, araddr, wdata, wstrb);
      end
      rstn = 1;
      @(negedge clk);
      total++;
      if ({busy, cmd_ready} !== 2'b01) begin
         bad++;
         $display("FAIL reset_release got=%b exp=01", {busy, cmd_ready});
      end
   endtask

   task automatic test_write();
      logic [DW-1:0] rd, erd;
      logic [1:0] rr, err;
      logic rw;
      int lat, aw0, w0;
      bit tmo;
      aw_wait = 1; w_wait = 3; b_wait = 0; s_bresp = RESP_OKAY;
      aw0 = aw_hs_n; w0 = w_hs_n;
      model_apply(1, 16'h0008, 32'hDEADBEEF, 4'hF, erd, err);
      do_cmd(1, 16'h0008, 32'hDEADBEEF, 4'hF, rd, rr, rw, lat, tmo);
      total++;
      if (tmo || rd !== erd || rr !== err || rw !== 1'b1) begin
         bad++;
         $display("FAIL write_rsp got tmo=%0b d=%h r=%b w=%b exp d=%h r=%b w=1",
                  tmo, rd, rr, rw, erd, err);
      end
      total++;
      if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1) begin
         bad++;
         $display("FAIL write_hs_count got aw=%0d w=%0d exp 1 1",
                  aw_hs_n - aw0, w_hs_n - w0);
      end
      total++;
      if (s_awaddr !== 16'h0008 || s_wdata !== 32'hDEADBEEF ||
          s_wstrb !== 4'hF) begin
         bad++;
         $display("FAIL write_payload got a=%h d=%h s=%h exp 0008 deadbeef f",
                  s_awaddr, s_wdata, s_wstrb);
      end
   endtask

   task automatic test_read();
      logic [DW-1:0] rd, erd;
      logic [1:0] rr, err;
      logic rw;
      int lat;
      bit tmo;
      aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 2;
      s_rresp = RESP_OKAY;
      model_apply(0, 16'h0004, '0, '0, erd, err);
      do_cmd(0, 16'h0004, '0, '0, rd, rr, rw, lat, tmo);
      total++;
      if (tmo || rd !== erd || rr !== err || rw !== 1'b0) begin
         bad++;
         $display("FAIL read_rsp got tmo=%0b d=%h r=%b w=%b exp d=%h r=%b w=0",
                  tmo, rd, rr, rw, erd, err);
      end
      total++;
      if (s_araddr !== 16'h0004 || busy !== 1'b0) begin
         bad++;
         $display("FAIL read_addr_busy got a=%h busy=%b exp 0004 0",
                  s_araddr, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] rd, erd, d;
      logic [1:0] rr, err;
      logic rw;
      int lat;
      bit tmo;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      s_bresp = RESP_OKAY; s_rresp = RESP_OKAY;
      d = $urandom;
      model_apply(1, 16'h000C, d, 4'hF, erd, err);
      do_cmd(1, 16'h000C, d, 4'hF, rd, rr, rw, lat, tmo);
      total++;
      if (tmo || lat != 3 || rr !== err || rw !== 1'b1) begin
         bad++;
         $display("FAIL b2b_write got tmo=%0b lat=%0d r=%b exp lat=3 r=%b",
                  tmo, lat, rr, err);
      end
      model_apply(0, 16'h000C, '0, '0, erd, err);
      do_cmd(0, 16'h000C, '0, '0, rd, rr, rw, lat, tmo);
      total++;
      if (tmo || lat != 3 || rd !== erd || rw !== 1'b0) begin
         bad++;
         $display("FAIL b2b_read got tmo=%0b lat=%0d d=%h exp lat=3 d=%h",
                  tmo, lat, rd, erd);
      end
      total++;
      if (rb_viol != 0) begin
         bad++;
         $display("FAIL ready_vs_busy got=%0d exp=0", rb_viol);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] rd, erd, d;
      logic [1:0] rr, err;
      logic [3:0] s;
      logic [AW-1:0] a;
      logic rw;
      bit w, tmo;
      int lat;
      for (int i = 0; i < 24; i++) begin
         w = bit'($urandom_range(0, 1));
         a = AW'($urandom_range(0, 15) * 4);
         d = $urandom;
         s = 4'($urandom);
         aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
         ar_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
         r_wait  = $urandom_range(0, 3);
         s_bresp = 2'($urandom); s_rresp = 2'($urandom);
         model_apply(w, a, d, s, erd, err);
         do_cmd(w, a, d, s, rd, rr, rw, lat, tmo);
         total++;
         if (tmo || rd !== erd || rr !== err || rw !== w) begin
            bad++;
            $display("FAIL rand[%0d] w=%0b a=%h got tmo=%0b d=%h r=%b rw=%b exp d=%h r=%b",
                     i, w, a, tmo, rd, rr, rw, erd, err);
         end
      end
   endtask

   task automatic test_rsp_hold();
      logic [DW-1:0] rd, erd;
      logic [1:0] rr, err;
      logic rw;
      int lat;
      bit tmo;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      s_rresp = RESP_SLVERR;
      rsp_ready = 0;
      model_apply(0, 16'h0008, '0, '0, erd, err);
      do_cmd(0, 16'h0008, '0, '0, rd, rr, rw, lat, tmo);
      total++;
      if (tmo || rr !== RESP_SLVERR || rd !== erd) begin
         bad++;
         $display("FAIL hold_first got tmo=%0b r=%b d=%h exp r=10 d=%h",
                  tmo, rr, rd, erd);
      end
      cmd_write = 1; cmd_addr = 16'h0030; cmd_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid, rsp_resp, rsp_rdata, cmd_ready, awvalid} !==
             {1'b1, RESP_SLVERR, erd, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL hold_cyc%0d got v=%b r=%b d=%h rdy=%b awv=%b exp 1 10 %h 0 0",
                     i, rsp_valid, rsp_resp, rsp_rdata, cmd_ready,
                     awvalid, erd);
         end
      end
      cmd_valid = 0;
      rsp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({rsp_valid, busy} !== 2'b00) begin
         bad++;
         $display("FAIL hold_release got v=%b busy=%b exp 0 0",
                  rsp_valid, busy);
      end
      s_rresp = RESP_OKAY;
   endtask

   task automatic test_mid_reset();
      logic [DW-1:0] rd, erd, d;
      logic [1:0] rr, err;
      logic rw;
      int lat, n;
      bit tmo;
      aw_wait = 0; w_wait = 0; b_wait = 8; s_bresp = RESP_OKAY;
      d = $urandom;
      model_apply(1, 16'h0010, d, 4'hF, erd, err);
      cmd_write = 1; cmd_addr = 16'h0010; cmd_wdata = d;
      cmd_wstrb = 4'hF; cmd_valid = 1;
      @(posedge clk);
      #1 cmd_valid = 0;
      n = 0;
      while (!bready && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (bready !== 1'b1) begin
         bad++;
         $display("FAIL midrst_reach got bready=%b exp=1", bready);
      end
      #2 rstn = 0;
      #1;
      total++;
      if ({bready, busy, rsp_valid} !== 3'b000) begin
         bad++;
         $display("FAIL midrst_async got=%b exp=000",
                  {bready, busy, rsp_valid});
      end
      b_wait = 0;
      repeat (2) @(negedge clk);
      rstn = 1;
      @(negedge clk);
      total++;
      if ({rsp_valid, error, cmd_ready} !== 3'b001) begin
         bad++;
         $display("FAIL midrst_quiet got=%b exp=001",
                  {rsp_valid, error, cmd_ready});
      end
      d = $urandom;
      model_apply(1, 16'h0014, d, 4'h5, erd, err);
      do_cmd(1, 16'h0014, d, 4'h5, rd, rr, rw, lat, tmo);
      total++;
      if (tmo || lat != 3 || rr !== err || rw !== 1'b1) begin
         bad++;
         $display("FAIL midrst_after got tmo=%0b lat=%0d r=%b exp lat=3 r=%b",
                  tmo, lat, rr, err);
      end
      model_apply(0, 16'h0010, '0, '0, erd, err);
      do_cmd(0, 16'h0010, '0, '0, rd, rr, rw, lat, tmo);
      total++;
      if (tmo || rd !== erd) begin
         bad++;
         $display("FAIL midrst_readback got tmo=%0b d=%h exp d=%h",
                  tmo, rd, erd);
      end
   endtask

   task automatic test_watchdog();
      int n, leaks;
      ar_never = 1;
      cmd_write = 0; cmd_addr = 16'h0020; cmd_valid = 1;
      @(posedge clk);
      #1 cmd_valid = 0;
      n = 0;
      @(negedge clk);
      while (arvalid && n < 40) begin
         n++;
         @(negedge clk);
      end
      total++;
      if (n != TO) begin
         bad++;
         $display("FAIL wdog_arvalid_cycles got=%0d exp=%0d", n, TO);
      end
      total++;
      if ({error, arvalid, cmd_ready, busy} !== 4'b1001) begin
         bad++;
         $display("FAIL wdog_state got err,arv,rdy,busy=%b exp=1001",
                  {error, arvalid, cmd_ready, busy});
      end
      leaks = 0;
      cmd_write = 1; cmd_valid = 1;
      repeat (6) begin
         @(negedge clk);
         if (cmd_ready || awvalid || arvalid || !error) leaks++;
      end
      cmd_valid = 0;
      total++;
      if (leaks != 0) begin
         bad++;
         $display("FAIL wdog_sticky got=%0d bad cycles exp=0", leaks);
      end
      rstn = 0;
      #1;
      total++;
      if ({error, busy} !== 2'b00) begin
         bad++;
         $display("FAIL wdog_reset got err,busy=%b exp=00", {error, busy});
      end
      ar_never = 0;
      @(negedge clk);
      rstn = 1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      @(negedge clk);
      test_write();
      test_read();
      test_back_to_back();
      test_random();
      test_rsp_hold();
      test_mid_reset();
      test_watchdog();
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL payload_stability got=%0d exp=0", viol);
      end
      total++;
      if (rb_viol != 0) begin
         bad++;
         $display("FAIL ready_busy_final got=%0d exp=0", rb_viol);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=hung exp=finish");
      $fatal(1, "bench timeout");
   end

endmodule
